// File: rtl/mem_ctrl.sv
// Main-memory controller: serves one block request at a time from the icache and dcache ports
// (icache has fixed priority), with a fixed access latency over an internal block array.
module mem_ctrl #(
  parameter int N_BLOCKS      = 1024,
  parameter int BLOCK_WIDTH   = 64,
  parameter int MEM_LATENCY   = 10,
  localparam int BLOCK_ADDR_WIDTH = $clog2(N_BLOCKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        icache_req_valid,
  input  logic                        icache_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
  input  logic [BLOCK_WIDTH-1:0]      icache_req_block_data,
  output logic                        icache_req_ready,
  output logic                        icache_resp_valid,
  output logic [BLOCK_WIDTH-1:0]      icache_resp_block_data,
  input  logic                        dcache_req_valid,
  input  logic                        dcache_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
  input  logic [BLOCK_WIDTH-1:0]      dcache_req_block_data,
  output logic                        dcache_req_ready,
  output logic                        dcache_resp_valid,
  output logic [BLOCK_WIDTH-1:0]      dcache_resp_block_data,
  input  logic                        init_wr_en,
  input  logic [BLOCK_ADDR_WIDTH-1:0] init_wr_addr,
  input  logic [BLOCK_WIDTH-1:0]      init_wr_data
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  owner_t                      owner_q, owner_d;
  req_type_t                   type_q, type_d;
  logic [BLOCK_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0]      data_q, data_d;
  logic                        i_resp_valid_q, i_resp_valid_d;
  logic                        d_resp_valid_q, d_resp_valid_d;
  logic [BLOCK_WIDTH-1:0]      i_resp_data_q, i_resp_data_d;
  logic [BLOCK_WIDTH-1:0]      d_resp_data_q, d_resp_data_d;
  logic                        mem_we;
  logic [BLOCK_WIDTH-1:0]      mem_q [N_BLOCKS];

  assign icache_req_ready       = (state_q == IDLE);
  assign dcache_req_ready       = (state_q == IDLE) & ~icache_req_valid;
  assign icache_resp_valid      = i_resp_valid_q;
  assign dcache_resp_valid      = d_resp_valid_q;
  assign icache_resp_block_data = i_resp_data_q;
  assign dcache_resp_block_data = d_resp_data_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    type_d         = type_q;
    addr_d         = addr_q;
    data_d         = data_q;
    i_resp_valid_d = 1'b0;
    d_resp_valid_d = 1'b0;
    i_resp_data_d  = i_resp_data_q;
    d_resp_data_d  = d_resp_data_q;
    mem_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (icache_req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          owner_d = OWN_I;
          type_d  = req_type_t'(icache_req_type);
          addr_d  = icache_req_block_addr;
          data_d  = icache_req_block_data;
        end else if (dcache_req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          owner_d = OWN_D;
          type_d  = req_type_t'(dcache_req_type);
          addr_d  = dcache_req_block_addr;
          data_d  = dcache_req_block_data;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          if (type_q == REQ_READ) begin
            // Route the block strictly to the latched owner, independent of current valids.
            if (owner_q == OWN_I) begin
              i_resp_valid_d = 1'b1;
              i_resp_data_d  = mem_q[addr_q];
            end else begin
              d_resp_valid_d = 1'b1;
              d_resp_data_d  = mem_q[addr_q];
            end
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      i_resp_valid_q <= i_resp_valid_d;
      d_resp_valid_q <= d_resp_valid_d;
      i_resp_data_q  <= i_resp_data_d;
      d_resp_data_q  <= d_resp_data_d;
    end
  end

  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    type_q  <= type_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
  end

  // Transaction write is issued after the preload write so it wins a same-block collision.
  always_ff @(posedge clk) begin
    if (init_wr_en) begin
      mem_q[init_wr_addr] <= init_wr_data;
    end
    if (mem_we && !rst) begin
      mem_q[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: transaction-level reference model plus directed and random traffic.
module tb_mem_ctrl;
  localparam int N_BLOCKS    = 1024;
  localparam int BLOCK_WIDTH = 64;
  localparam int MEM_LATENCY = 10;
  localparam int AW          = $clog2(N_BLOCKS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic icache_req_valid = 1'b0, icache_req_type = 1'b0;
  logic [AW-1:0] icache_req_block_addr = '0;
  logic [BLOCK_WIDTH-1:0] icache_req_block_data = '0;
  logic icache_req_ready, icache_resp_valid;
  logic [BLOCK_WIDTH-1:0] icache_resp_block_data;
  logic dcache_req_valid = 1'b0, dcache_req_type = 1'b0;
  logic [AW-1:0] dcache_req_block_addr = '0;
  logic [BLOCK_WIDTH-1:0] dcache_req_block_data = '0;
  logic dcache_req_ready, dcache_resp_valid;
  logic [BLOCK_WIDTH-1:0] dcache_resp_block_data;
  logic init_wr_en = 1'b0;
  logic [AW-1:0] init_wr_addr = '0;
  logic [BLOCK_WIDTH-1:0] init_wr_data = '0;

  mem_ctrl #(.N_BLOCKS(N_BLOCKS), .BLOCK_WIDTH(BLOCK_WIDTH), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clk(clk), .rst(rst),
    .icache_req_valid(icache_req_valid), .icache_req_type(icache_req_type),
    .icache_req_block_addr(icache_req_block_addr), .icache_req_block_data(icache_req_block_data),
    .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr), .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_ready(dcache_req_ready), .dcache_resp_valid(dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data),
    .init_wr_en(init_wr_en), .init_wr_addr(init_wr_addr), .init_wr_data(init_wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  // Reference model: a memory array and at most one transaction in flight, with a completion edge.
  logic [63:0] ref_mem [N_BLOCKS];
  bit          m_busy = 1'b0;
  int          m_due = 0;
  bit          t_owner_d, t_wr;
  logic [AW-1:0] t_addr;
  logic [63:0] t_data, rd;
  bit          done;
  bit          exp_idle = 1'b1;
  logic [63:0] exp_i_data = '0, exp_d_data = '0;
  logic [63:0] exp_iq[$], exp_dq[$];

  always @(posedge clk) begin
    ecount++;
    done = m_busy && !rst && (ecount == m_due);
    if (done && !t_wr) begin
      rd = ref_mem[t_addr];
      if (t_owner_d) begin exp_dq.push_back(rd); exp_d_data = rd; end
      else begin exp_iq.push_back(rd); exp_i_data = rd; end
    end
    if (init_wr_en) ref_mem[init_wr_addr] = init_wr_data;
    if (rst) begin
      m_busy = 1'b0; exp_i_data = '0; exp_d_data = '0;
      exp_iq.delete(); exp_dq.delete();
    end else if (done) begin
      if (t_wr) ref_mem[t_addr] = t_data;
      m_busy = 1'b0;
    end else if (!m_busy && (icache_req_valid || dcache_req_valid)) begin
      m_busy    = 1'b1;
      m_due     = ecount + MEM_LATENCY;
      t_owner_d = !icache_req_valid;
      t_wr      = t_owner_d ? dcache_req_type : icache_req_type;
      t_addr    = t_owner_d ? dcache_req_block_addr : icache_req_block_addr;
      t_data    = t_owner_d ? dcache_req_block_data : icache_req_block_data;
    end
    exp_idle = !m_busy;
  end

  // Monitor: readies every cycle; response pulses pop the scoreboard queues.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("i_ready", icache_req_ready, exp_idle);
      chk("d_ready", dcache_req_ready, exp_idle & ~icache_req_valid);
      if (exp_iq.size() != 0) begin
        chk("i_resp_valid", icache_resp_valid, 1'b1);
        chk("i_resp_data", icache_resp_block_data, exp_iq.pop_front());
      end else begin
        chk("i_resp_valid", icache_resp_valid, 1'b0);
        chk("i_resp_hold", icache_resp_block_data, exp_i_data);
      end
      if (exp_dq.size() != 0) begin
        chk("d_resp_valid", dcache_resp_valid, 1'b1);
        chk("d_resp_data", dcache_resp_block_data, exp_dq.pop_front());
      end else begin
        chk("d_resp_valid", dcache_resp_valid, 1'b0);
        chk("d_resp_hold", dcache_resp_block_data, exp_d_data);
      end
    end
  end

  // Issue a request on one port and hold it until accepted; returns the accepting edge number.
  task automatic req(input bit port_d, input bit wr, input logic [AW-1:0] a,
                     input logic [63:0] d, output int acc);
    acc = -1;
    if (port_d) begin
      dcache_req_valid = 1'b1; dcache_req_type = wr; dcache_req_block_addr = a; dcache_req_block_data = d;
    end else begin
      icache_req_valid = 1'b1; icache_req_type = wr; icache_req_block_addr = a; icache_req_block_data = d;
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (port_d ? dcache_req_ready : icache_req_ready) begin
        @(posedge clk); #1;
        acc = ecount;
        break;
      end
    end
    if (port_d) dcache_req_valid = 1'b0; else icache_req_valid = 1'b0;
    if (acc < 0) chk(port_d ? "d_accept_timeout" : "i_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_resp(input bit port_d, input logic [63:0] exp, input string nm, input int acc);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (port_d ? dcache_resp_valid : icache_resp_valid) begin
        seen = 1'b1;
        chk({nm, "_data"}, port_d ? dcache_resp_block_data : icache_resp_block_data, exp);
        chk({nm, "_latency"}, 64'(ecount - acc), 64'(MEM_LATENCY));
      end
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [63:0] d);
    init_wr_en = 1'b1; init_wr_addr = a; init_wr_data = d;
    @(posedge clk); #1;
    init_wr_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    @(posedge clk); #1;
    mon_on = 1'b1;
    for (int i = 0; i < 32; i++) preload(AW'(i), {$urandom, $urandom});
    preload(AW'(5), 64'hDEAD_BEEF_0000_0001);
    preload(AW'(9), 64'hAA);
    chk("rst_i_ready", icache_req_ready, 1'b1);
    chk("rst_d_ready", dcache_req_ready, 1'b1);
    chk("rst_d_resp_data", dcache_resp_block_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Preload and read
    req(1'b1, 1'b0, AW'(5), 64'd0, a1);
    wait_resp(1'b1, 64'hDEAD_BEEF_0000_0001, "preload_read", a1);

    // Write then read
    req(1'b1, 1'b1, AW'(7), 64'h1234, a1);
    req(1'b1, 1'b0, AW'(7), 64'd0, a2);
    chk("raw_spacing", 64'(a2 - a1), 64'(MEM_LATENCY + 1));
    wait_resp(1'b1, 64'h1234, "raw_read", a2);

    // Contention
    fork
      req(1'b0, 1'b0, AW'(1), 64'd0, a1);
      req(1'b1, 1'b0, AW'(2), 64'd0, a2);
    join
    chk("contention_order", 64'(a2 - a1), 64'(MEM_LATENCY + 1));
    repeat (MEM_LATENCY + 2) @(posedge clk);
    #1;

    // Busy blocking
    fork
      req(1'b0, 1'b0, AW'(3), 64'd0, a1);
      begin repeat (3) @(posedge clk); #1; req(1'b1, 1'b0, AW'(4), 64'd0, a2); end
    join
    chk("busy_block_accept", 64'(a2 - a1), 64'(MEM_LATENCY + 1));
    repeat (MEM_LATENCY + 2) @(posedge clk);
    #1;

    // Reset mid-transaction
    req(1'b1, 1'b1, AW'(9), 64'h55, a1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_i_ready", icache_req_ready, 1'b1);
    chk("post_rst_d_ready", dcache_req_ready, 1'b1);
    req(1'b1, 1'b0, AW'(9), 64'd0, a1);
    wait_resp(1'b1, 64'hAA, "rst_drop_read", a1);

    // Init collision
    req(1'b1, 1'b1, AW'(12), 64'hC0FFEE, a1);
    repeat (MEM_LATENCY - 1) @(posedge clk);
    #1;
    preload(AW'(12), 64'hBAD);
    req(1'b1, 1'b0, AW'(12), 64'd0, a1);
    wait_resp(1'b1, 64'hC0FFEE, "init_collision_read", a1);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      int mode;
      bit wi, wd;
      logic [AW-1:0] ai, ad;
      logic [63:0] di, dd;
      mode = $urandom_range(0, 2);
      wi = 1'($urandom); wd = 1'($urandom);
      ai = AW'($urandom_range(0, 31)); ad = AW'($urandom_range(0, 31));
      di = {$urandom, $urandom}; dd = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) preload(AW'($urandom_range(0, 31)), {$urandom, $urandom});
      case (mode)
        0: req(1'b0, wi, ai, di, a1);
        1: req(1'b1, wd, ad, dd, a2);
        default: fork
          req(1'b0, wi, ai, di, a1);
          req(1'b1, wd, ad, dd, a2);
        join
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    repeat (MEM_LATENCY + 4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Main-memory controller: the responder side of the cache/memory-controller protocol used by the instruction and data caches. It arbitrates one outstanding block request at a time between the icache and dcache ports, with icache at fixed priority. It models main memory as an internal block array with a fixed access latency and returns read blocks to the requesting cache. It sits between both caches and the backing memory model, and is the counterpart of the caches' `mem_ctrl_req_*` / `mem_ctrl_resp_*` ports.

## Interface
- `N_BLOCKS`, 1024: main-memory size in blocks; must be a power of two.
- `BLOCK_WIDTH`, 64: block data width in bits (`block_data_t`).
- `MEM_LATENCY`, 10: cycles from request acceptance to completion; must be ≥1.
- `BLOCK_ADDR_WIDTH` (localparam): `clog2(N_BLOCKS)` (`main_mem_block_addr_t`).

- `clk`  in  1  sole clock; everything is sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `icache_req_valid`  in  1  icache request valid; held until accepted.
- `icache_req_type`  in  1  `req_type_t`; 0 = read, 1 = write.
- `icache_req_block_addr`  in  BLOCK_ADDR_WIDTH  block address.
- `icache_req_block_data`  in  BLOCK_WIDTH  write data (ignored for reads).
- `icache_req_ready`  out  1  controller accepts the icache request this cycle.
- `icache_resp_valid`  out  1  one-cycle read-data pulse to the icache.
- `icache_resp_block_data`  out  BLOCK_WIDTH  read block.
- `dcache_req_valid`, `dcache_req_type`, `dcache_req_block_addr`, `dcache_req_block_data`  in  same widths as the icache request ports  dcache request.
- `dcache_req_ready`  out  1  controller accepts the dcache request this cycle.
- `dcache_resp_valid`  out  1  one-cycle read-data pulse to the dcache.
- `dcache_resp_block_data`  out  BLOCK_WIDTH  read block.
- `init_wr_en`  in  1  testbench preload write enable.
- `init_wr_addr`  in  BLOCK_ADDR_WIDTH  preload block address.
- `init_wr_data`  in  BLOCK_WIDTH  preload data.

## Operation
- FSM has two states: IDLE and BUSY.
- **Ready logic:**
  - `icache_req_ready = (state==IDLE)`.
  - `dcache_req_ready = (state==IDLE) & ~icache_req_valid`.
  - Ready is combinational from state and `icache_req_valid` only; it never depends on the dcache request fields.
- **Acceptance:** a request is accepted on a rising edge where valid & ready.
  - Latched on acceptance: owner (I/D), type, address and data.
  - Next state: BUSY, with `cnt <= MEM_LATENCY-1`.
- **BUSY:**
  - While `cnt != 0`: `cnt <= cnt-1`.
  - On the edge where `cnt == 0`, the transaction completes and the state returns to IDLE.
    - Read: the owner's `resp_block_data <= mem[addr]` and the owner's `resp_valid <= 1` for exactly one cycle.
    - Write: `mem[addr] <= data`. A write produces no response pulse.
- Both caches see a single serialized stream, so read-after-write ordering is guaranteed.
- `init_wr_en` writes `mem[init_wr_addr]` on any edge, regardless of state. If it hits the same block as a completing write on the same edge, the transaction write wins.
- Memory contents are not affected by `rst`; they change only through writes and init.

## Timing
- **Reset values:** state IDLE, `cnt` 0, both `resp_valid` 0, both `resp_block_data` 0.
  - Coming out of reset, `icache_req_ready` = 1 and `dcache_req_ready` = `~icache_req_valid`.
- **Read latency:** request accepted at edge E0 → completes at edge E_MEM_LATENCY → `resp_valid` high during the cycle after E_MEM_LATENCY.
  - With `MEM_LATENCY` = 1, the response is visible the cycle after the accepting edge's successor.
- **Back-to-back:** ready reasserts in the same cycle `resp_valid` is high. Minimum acceptance-to-acceptance spacing is `MEM_LATENCY`+1 edges.
- `resp_block_data` holds its last read value until the next read response to that port. `resp_valid` pulses are never back-to-back closer than that spacing.
- **Simultaneous valid from both ports in IDLE:** icache is accepted. The dcache request waits; it must hold valid and fields stable.
- **Request while BUSY:** not accepted; no internal queueing.
- **Reset asserted mid-BUSY:**
  - The transaction is dropped: no response and no memory write.
  - Outputs return to reset values on that edge.
- A request is never delivered to the wrong port's response, even if the owner drops valid after acceptance (valid is a don't-care once accepted).

## Test plan
- **Preload and read:** init `mem[5]=64'hDEAD_BEEF_0000_0001`; dcache read addr 5, `MEM_LATENCY`=10 → `dcache_resp_valid` is a single pulse 10 edges after acceptance with that data; `icache_resp_valid` stays 0.
- **Write then read:** dcache write addr 7 data `64'h1234`; dcache read addr 7 →
  - no response for the write;
  - read returns `64'h1234`;
  - second acceptance occurs exactly 11 edges after the first.
- **Contention:** icache read addr 1 and dcache read addr 2 valid in the same IDLE cycle →
  - icache accepted first, dcache_ready 0 that cycle;
  - icache response, then dcache accepted the next cycle;
  - each response goes only to its owner.
- **Busy blocking:** assert dcache_valid during BUSY → ready stays 0 until the response cycle; acceptance happens on the edge ending the response cycle.
- **Reset mid-transaction:** start a dcache write to addr 9 (old value `64'hAA`), assert `rst` at `cnt`=3 →
  - no resp pulse;
  - `mem[9]` still `64'hAA`;
  - both readies valid immediately after reset.
- **Init collision:** init write and transaction write completion to the same block on the same edge → the subsequent read returns the transaction data.
